// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ctrl
//  Purpose  : MEM-stage controller. Owns the MEM valid bit, drives allowin
//             back to the EXE->MEM register, runs the split-transaction
//             data-memory handshake (req / addr_ok / data_ok) and drains an
//             in-flight access when the pipeline is flushed.
//  Options  : MEM_ALIGN_CHECK_EN - raise AdEL/AdES on misaligned word
//             accesses instead of issuing them.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exe_to_mem_valid,
    output logic              mem_allowin,
    input  logic              wb_allowin,
    output logic              mem_to_wb_valid,
    input  logic              flush,
    input  logic              mem_rd,
    input  logic              dmem_we,
    input  logic              ex,
    input  logic              eret_flush,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rt,
    output logic              dmem_req,
    output logic              dmem_wr,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_addr_ok,
    input  logic              dmem_data_ok,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] load_data,
    output logic              ex_out,
    output logic [4:0]        ex_code_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;

    logic w_is_mem;     // instruction touches data memory
    logic w_misalign;   // misaligned word access (only with the check enabled)
    logic w_is_acc;     // valid instruction that really needs the memory
    logic w_acc;        // ... and is not being killed this cycle
    logic w_req;        // request is being presented this cycle
    logic w_done;       // access completes this cycle
    logic w_ready_go;
    logic w_leave;      // instruction hands over to WB at the next edge

    assign w_is_mem = mem_rd | dmem_we;

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    assign w_misalign  = w_is_mem & (alu_result[1:0] != 2'b00);
    assign ex_code_out = (mem_valid_q & ~ex & w_misalign) ?
                         (mem_rd ? EXC_ADEL : EXC_ADES) : 5'h00;
`else
    assign w_misalign  = 1'b0;
    assign ex_code_out = 5'h00;
`endif

    assign w_is_acc = mem_valid_q & w_is_mem & ~ex & ~eret_flush & ~w_misalign;
    assign w_acc    = w_is_acc & ~flush;

    // IDLE behaves as REQ in the same cycle so the first request is zero-latency.
    // Once in REQ the request is held even under flush; it drops next cycle.
    assign w_req  = ((state_q == S_IDLE) & w_acc) | (state_q == S_REQ);
    assign w_done = (w_req & dmem_addr_ok & dmem_data_ok) |
                    ((state_q == S_WAIT) & dmem_data_ok);

    // Stage may advance: non-access instructions immediately, accesses on completion.
    always_comb begin
        w_ready_go = 1'b1;
        if (state_q == S_DRAIN) begin
            w_ready_go = 1'b0;
        end else if (w_is_acc) begin
            w_ready_go = w_done | (state_q == S_DONE);
        end
    end

    assign mem_to_wb_valid = mem_valid_q & w_ready_go & ~flush;
    assign w_leave         = mem_to_wb_valid & wb_allowin;

    // Never accept a new instruction while an orphaned response is still due,
    // nor in the cycle a pending request is being abandoned.
    assign mem_allowin = (~mem_valid_q | (w_ready_go & wb_allowin)) &
                         (state_q != S_DRAIN) &
                         ~((state_q == S_REQ) & flush & ~dmem_addr_ok);

    assign dmem_req   = w_req;
    assign dmem_wr    = dmem_we;
    assign dmem_addr  = alu_result;
    assign dmem_wdata = rt;
    assign load_data  = load_data_q;
    assign ex_out     = mem_valid_q & (ex | w_misalign);

    // Next-state logic for the memory handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_REQ: begin
                if ((state_q == S_REQ) && flush) begin
                    state_d = (dmem_addr_ok && !dmem_data_ok) ? S_DRAIN : S_IDLE;
                end else if (w_req) begin
                    if (!dmem_addr_ok) begin
                        state_d = S_REQ;
                    end else if (!dmem_data_ok) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = w_leave ? S_IDLE : S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = dmem_data_ok ? S_IDLE : S_DRAIN;
                end else if (dmem_data_ok) begin
                    state_d = w_leave ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                if (flush || w_leave) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dmem_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valid bit and captured load data; a flushed response is never captured.
    always_comb begin
        mem_valid_d = mem_valid_q;
        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (mem_allowin) begin
            mem_valid_d = exe_to_mem_valid;
        end
        load_data_d = load_data_q;
        if (w_done && mem_rd && !flush) begin
            load_data_d = dmem_rdata;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_valid_q <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            load_data_q <= load_data_d;
        end
    end

endmodule
`default_nettype wire
